apb_master_bridge: RTL and testbench

- APB4 requester (initiator) that drives the timer's APB responder port from a simple valid/ready command interface.
- Performs one SETUP+ACCESS transfer per command, honours PREADY wait states, reports PSLVERR and returns PRDATA.
- Aborts with an error if the responder stalls past a configurable timeout.
- Used by the SoC-side host logic and as a synthesizable stimulus source for the timer.

---
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Purpose : APB4 requester; turns one valid/ready command into one SETUP+ACCESS transfer.
// Latency : accept at edge N -> psel after N, penable after N+1, rsp_valid after N+2+wait_states.
// Backpr. : cmd_ready only in IDLE (one command in flight); rsp_valid is a pulse with no backpressure.
//
// Ports:
//   sys_clk, sys_rst_n              clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_write/addr/wdata/strb are the payload
//   rsp_valid                       one-cycle completion pulse
//   rsp_rdata/rsp_err/rsp_timeout   completion status, held until the next completion
//   tim_p*                          APB4 requester port towards the timer
module apb_master_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pready,
  input  logic                tim_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the stalled cycle that would bring the count up to TIMEOUT,
  // so ACCESS lasts exactly TIMEOUT cycles when the responder never answers.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             xfer_done;
  logic             xfer_abort;
  logic             cnt_hit;

  assign accept     = cmd_valid & cmd_ready;
  // tim_penable is implied by S_ACCESS, so pslverr is only ever looked at here.
  assign xfer_done  = (state == S_ACCESS) & tim_pready;
  assign cnt_hit    = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);
  // pready on the same cycle as the count hit wins over the abort.
  assign xfer_abort = (state == S_ACCESS) & ~tim_pready & cnt_hit;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (xfer_done || xfer_abort) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; reset clears state asynchronously, so psel and
  // penable drop the moment reset asserts.
  always_comb begin
    cmd_ready   = 1'b0;
    tim_psel    = 1'b0;
    tim_penable = 1'b0;
    case (state)
      S_IDLE:   cmd_ready = 1'b1;
      S_SETUP:  tim_psel  = 1'b1;
      S_ACCESS: begin
        tim_psel    = 1'b1;
        tim_penable = 1'b1;
      end
      default:  cmd_ready = 1'b0;
    endcase
  end

  // Stall counter: cleared in SETUP so it starts at zero on entering ACCESS,
  // saturates instead of wrapping (matters only when TIMEOUT is 0).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == S_ACCESS) && !tim_pready && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // APB address/data registers: loaded only on accept, so they are stable
  // through SETUP and ACCESS and keep their last values while idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tim_pwrite <= 1'b0;
      tim_paddr  <= '0;
      tim_pwdata <= '0;
      tim_pstrb  <= '0;
    end else if (accept) begin
      tim_pwrite <= cmd_write;
      tim_paddr  <= cmd_addr;
      // Reads drive zero data and strobes on the bus.
      tim_pwdata <= cmd_write ? cmd_wdata : '0;
      tim_pstrb  <= cmd_write ? cmd_strb  : {STRB_W{1'b0}};
    end
  end

  // Response registers: pulse rsp_valid, hold status until the next completion.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= xfer_done | xfer_abort;
      if (xfer_done) begin
        rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
        rsp_err     <= tim_pslverr;
        rsp_timeout <= 1'b0;
      end else if (xfer_abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata = '0;
  logic        tim_pready = 1'b0;
  logic        tim_pslverr = 1'b0;

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .tim_psel   (tim_psel),
    .tim_penable(tim_penable),
    .tim_pwrite (tim_pwrite),
    .tim_paddr  (tim_paddr),
    .tim_pwdata (tim_pwdata),
    .tim_pstrb  (tim_pstrb),
    .tim_prdata (tim_prdata),
    .tim_pready (tim_pready),
    .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  // One directed transfer: command, responder behaviour and hand-computed response.
  // waits = number of ACCESS cycles with pready=0 before pready=1 (>=TMO means never).
  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [50:0] apb_vec();
    return {tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge one cycle after completion.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ewd;
    logic [3:0]  est;
    int          k;
    bit          got;
    ewd = v.wr ? v.wdata : 32'h0;
    est = v.wr ? v.strb  : 4'h0;
    cmd_write   = v.wr;
    cmd_addr    = v.addr;
    cmd_wdata   = v.wdata;
    cmd_strb    = v.strb;
    cmd_valid   = 1'b1;
    tim_prdata  = v.prdata;
    tim_pslverr = v.slverr;
    tim_pready  = 1'b0;
    chk({tag, " cmd_ready before accept"}, 64'(cmd_ready), 64'(1'b1));
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk({tag, " setup phase"}, 64'(apb_vec()), 64'({1'b1, 1'b0, v.wr, v.addr, ewd, est}));
    chk({tag, " busy in setup"}, 64'({cmd_ready, rsp_valid}), 64'(2'b00));
    k   = 0;
    got = 0;
    while (!got && k < 12) begin
      @(negedge sys_clk);
      if (rsp_valid) begin
        got = 1;
      end else begin
        chk({tag, " access phase"}, 64'(apb_vec()), 64'({1'b1, 1'b1, v.wr, v.addr, ewd, est}));
        tim_pready = (k >= v.waits);
        k++;
      end
    end
    chk({tag, " completed"}, 64'(got), 64'(1));
    chk({tag, " access cycles"}, 64'(k), 64'(v.exp_acc));
    chk({tag, " rsp err/timeout/rdata"}, 64'({rsp_err, rsp_timeout, rsp_rdata}),
        64'({v.exp_err, v.exp_to, v.exp_rdata}));
    chk({tag, " idle after done"}, 64'({tim_psel, tim_penable, cmd_ready, tim_paddr}),
        64'({1'b0, 1'b0, 1'b1, v.addr}));
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;
    @(negedge sys_clk);
    chk({tag, " rsp pulse/hold"}, 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}),
        64'({1'b0, v.exp_err, v.exp_to, v.exp_rdata}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] b2b_addr [3];
    int          acc_c [3];
    int          idx;
    int          nrsp;
    int          nset;
    bit          pend;
    bit          saw_rsp;

    //         wr    addr     wdata         strb  waits prdata        slv   exp_rdata     err   to    acc
    vecs[0] = '{1'b1, 12'h004, 32'hA5A5_0001, 4'hF, 0,   32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 12'h000, 32'hDEAD_BEEF, 4'hF, 2,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, 12'h008, 32'h0000_0000, 4'h0, 0,   32'hCAFE_0000, 1'b1, 32'hCAFE_0000, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 12'h00C, 32'h0000_0000, 4'h0, 100, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4};
    vecs[4] = '{1'b0, 12'h010, 32'h0000_0000, 4'h0, 3,   32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 4};
    vecs[5] = '{1'b1, 12'hFFF, 32'h1122_3344, 4'h5, 1,   32'h9999_9999, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 2};
    vecs[6] = '{1'b0, 12'h014, 32'h0000_0000, 4'h0, 100, 32'h7777_7777, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 4};

    // Reset state
    #3;
    chk("reset controls", 64'({tim_psel, tim_penable, rsp_valid, rsp_err, rsp_timeout, cmd_ready}),
        64'(6'b000001));
    chk("reset data regs", 64'({tim_paddr, tim_pwrite, tim_pwdata, tim_pstrb, rsp_rdata}), 64'(0));
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back writes with cmd_valid held high and zero wait states
    b2b_addr[0] = 12'h020;
    b2b_addr[1] = 12'h024;
    b2b_addr[2] = 12'h028;
    tim_pready  = 1'b1;
    idx = 0; nrsp = 0; nset = 0; pend = 0;
    cmd_write = 1'b1;
    cmd_addr  = b2b_addr[0];
    cmd_wdata = 32'h0000_0100;
    cmd_strb  = 4'hF;
    cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (cmd_valid && cmd_ready) begin
        acc_c[idx] = c;
        pend = 1;
      end
      @(negedge sys_clk);
      if (pend) begin
        pend = 0;
        idx++;
        if (idx < 3) begin
          cmd_addr  = b2b_addr[idx];
          cmd_wdata = 32'h0000_0100 + 32'(idx);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid) nrsp++;
      if (tim_psel && !tim_penable && nset < 3) begin
        chk($sformatf("b2b setup addr %0d", nset), 64'(tim_paddr), 64'(b2b_addr[nset]));
        nset++;
      end
    end
    tim_pready = 1'b0;
    chk("b2b accepts", 64'(idx), 64'(3));
    if (idx == 3) begin
      chk("b2b spacing 0->1", 64'(acc_c[1] - acc_c[0]), 64'(3));
      chk("b2b spacing 1->2", 64'(acc_c[2] - acc_c[1]), 64'(3));
    end
    chk("b2b rsp pulses", 64'(nrsp), 64'(3));
    chk("b2b setups seen", 64'(nset), 64'(3));

    // Reset pulsed during ACCESS of a read
    cmd_write = 1'b0;
    cmd_addr  = 12'h030;
    cmd_valid = 1'b1;
    tim_prdata = 32'hFEED_FACE;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("rst-mid in access", 64'({tim_psel, tim_penable}), 64'(2'b11));
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst-mid async drop", 64'({tim_psel, tim_penable, cmd_ready}), 64'(3'b001));
    tim_pready = 1'b1;
    saw_rsp = 0;
    @(negedge sys_clk);
    if (rsp_valid) saw_rsp = 1;
    sys_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      if (rsp_valid) saw_rsp = 1;
    end
    chk("rst-mid no rsp", 64'(saw_rsp), 64'(0));
    chk("rst-mid idle after release", 64'({tim_psel, tim_penable, cmd_ready}), 64'(3'b001));
    tim_pready = 1'b0;
    run_vec(vecs[1], "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
